// File: rtl/neighborhood_loader.sv
`default_nettype none
// ============================================================================
// Module   : neighborhood_loader
// Brief    : Fetches the up/left/centre/right/down cross around one pixel and
//            packs it onto a 40-bit bus; off-image neighbours read as 8'h00.
// Revision : 1.0
// ============================================================================
module neighborhood_loader #(
  parameter int LOG2_W = 8,
  parameter int HEIGHT = 256,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LOG2_W-1:0] pix_x,
  input  logic [15:0]       pix_y,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              busy,
  output logic              valid,
  output logic [39:0]       cuarenta
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [16:0]       c_height = 17'(HEIGHT);
  localparam logic [LOG2_W-1:0] c_x_max  = '1;

  state_t              r_state;
  state_t              w_next_state;
  logic                w_load;
  logic [2:0]          r_k;
  logic [LOG2_W-1:0]   r_x;
  logic [15:0]         r_y;
  logic                r_top;
  logic                r_bot;
  logic                r_oob;
  logic                r_cap_en;
  logic                r_cap_skip;
  logic [2:0]          r_cap_k;
  logic [7:0]          r_up;
  logic [7:0]          r_left;
  logic [7:0]          r_centre;
  logic [7:0]          r_right;
  logic [39:0]         r_cuarenta;
  logic [LOG2_W-1:0]   w_slot_x;
  logic [15:0]         w_slot_y;
  logic                w_skip;
  logic [ADDR_W-1:0]   w_addr;
  logic [7:0]          w_byte;
  logic                w_in_top;
  logic                w_in_bot;
  logic                w_in_oob;

  assign w_in_top = (pix_y == 16'd0);
  assign w_in_bot = ({1'b0, pix_y} == (c_height - 17'd1));
  assign w_in_oob = ({1'b0, pix_y} >= c_height);

  // Neighbour coordinate and skip decision for the slot being issued.
  always_comb begin
    w_slot_x = r_x;
    w_slot_y = r_y;
    w_skip   = r_oob;
    case (r_k)
      3'd0: begin w_slot_y = r_y - 16'd1; w_skip = r_oob | r_top;              end
      3'd1: begin w_slot_x = r_x - 1'b1;  w_skip = r_oob | (r_x == '0);        end
      3'd2: begin                         w_skip = r_oob;                      end
      3'd3: begin w_slot_x = r_x + 1'b1;  w_skip = r_oob | (r_x == c_x_max);   end
      3'd4: begin w_slot_y = r_y + 16'd1; w_skip = r_oob | r_bot;              end
      default: w_skip = 1'b1;
    endcase
    w_addr = ADDR_W'({w_slot_y, w_slot_x});
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    mem_rd       = 1'b0;
    busy         = 1'b1;
    valid        = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next_state = ISSUE;
          w_load       = 1'b1;
        end
      end
      ISSUE: begin
        mem_rd = ~w_skip;
        if (r_k == 3'd4) w_next_state = DRAIN;
      end
      DRAIN: w_next_state = DONE;
      DONE: begin
        valid = 1'b1;
        // Back-to-back start keeps the 7-cycle throughput.
        if (start) begin
          w_next_state = ISSUE;
          w_load       = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
    mem_addr = mem_rd ? w_addr : '0;
  end

  assign w_byte = r_cap_skip ? 8'h00 : mem_data;

  // Data returns one cycle after its issue, so capture trails issue by one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k        <= 3'd0;
      r_x        <= '0;
      r_y        <= 16'd0;
      r_top      <= 1'b0;
      r_bot      <= 1'b0;
      r_oob      <= 1'b0;
      r_cap_en   <= 1'b0;
      r_cap_skip <= 1'b0;
      r_cap_k    <= 3'd0;
      r_up       <= 8'h00;
      r_left     <= 8'h00;
      r_centre   <= 8'h00;
      r_right    <= 8'h00;
      r_cuarenta <= 40'h0;
    end else begin
      if (w_load) begin
        r_x   <= pix_x;
        r_y   <= pix_y;
        r_top <= w_in_top;
        r_bot <= w_in_bot;
        r_oob <= w_in_oob;
        r_k   <= 3'd0;
      end else if (r_state == ISSUE) begin
        r_k <= r_k + 3'd1;
      end
      r_cap_en   <= (r_state == ISSUE);
      r_cap_k    <= r_k;
      r_cap_skip <= w_skip;
      if (r_cap_en) begin
        case (r_cap_k)
          3'd0:    r_up     <= w_byte;
          3'd1:    r_left   <= w_byte;
          3'd2:    r_centre <= w_byte;
          3'd3:    r_right  <= w_byte;
          default: ;
        endcase
      end
      // The down byte bypasses its slot so the bus is visible alongside valid.
      if (r_state == DRAIN) r_cuarenta <= {r_up, r_left, r_centre, r_right, w_byte};
    end
  end

  assign cuarenta = r_cuarenta;

endmodule
`default_nettype wire

// File: tb/tb_neighborhood_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_neighborhood_loader
// Brief    : Directed bench for neighborhood_loader with a mem[a]=a[7:0] model.
// Revision : 1.0
// ============================================================================
module tb_neighborhood_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  pix_x;
  logic [15:0] pix_y;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        busy;
  logic        valid;
  logic [39:0] cuarenta;

  int checks = 0;
  int errors = 0;

  neighborhood_loader #(
    .LOG2_W(8),
    .HEIGHT(256),
    .ADDR_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .busy     (busy),
    .valid    (valid),
    .cuarenta (cuarenta)
  );

  always #5 clk = ~clk;

  // One-cycle-latency memory; a poison byte appears when nothing was read.
  always @(posedge clk) mem_data <= mem_rd ? mem_addr[7:0] : 8'hEE;

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // rd_mask is {up,left,centre,right,down}; addresses checked only where read.
  task automatic run_pixel(input string name, input logic [7:0] x, input logic [15:0] y,
                           input logic [4:0] rd_mask, input int a0, input int a1,
                           input int a2, input int a3, input int a4,
                           input logic [39:0] exp_cue);
    int addrs [5];
    addrs = '{a0, a1, a2, a3, a4};
    start = 1'b1;
    pix_x = x;
    pix_y = y;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("%s rd%0d", name, k), 64'(mem_rd), 64'(rd_mask[4-k]));
      if (rd_mask[4-k]) check($sformatf("%s addr%0d", name, k), 64'(mem_addr), 64'(addrs[k]));
      check($sformatf("%s busy%0d", name, k), 64'(busy), 64'd1);
      check($sformatf("%s novalid%0d", name, k), 64'(valid), 64'd0);
      tick();
    end
    check({name, " drain_rd"}, 64'(mem_rd), 64'd0);
    check({name, " drain_valid"}, 64'(valid), 64'd0);
    tick();
    check({name, " valid"}, 64'(valid), 64'd1);
    check({name, " busy_done"}, 64'(busy), 64'd1);
    check({name, " cuarenta"}, 64'(cuarenta), 64'(exp_cue));
    tick();
    check({name, " valid_drop"}, 64'(valid), 64'd0);
    check({name, " idle_busy"}, 64'(busy), 64'd0);
    check({name, " cuarenta_hold"}, 64'(cuarenta), 64'(exp_cue));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    pix_x = 8'd0;
    pix_y = 16'd0;
    tick();
    tick();
    tick();
    // start high alongside rst must not launch a fetch
    check("reset mem_rd", 64'(mem_rd), 64'd0);
    check("reset mem_addr", 64'(mem_addr), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset valid", 64'(valid), 64'd0);
    check("reset cuarenta", 64'(cuarenta), 64'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("idle busy", 64'(busy), 64'd0);

    run_pixel("interior", 8'd10, 16'd5, 5'b11111, 1034, 1289, 1290, 1291, 1546, 40'h0A_09_0A_0B_0A);
    run_pixel("corner00", 8'd0, 16'd0, 5'b00111, 0, 0, 0, 1, 256, 40'h00_00_00_01_00);
    run_pixel("cornerFF", 8'd255, 16'd255, 5'b11100, 65279, 65534, 65535, 0, 0, 40'hFF_FE_FF_00_00);
    run_pixel("y300", 8'd7, 16'd300, 5'b00000, 0, 0, 0, 0, 0, 40'h0);

    // start held high: results every 7 cycles, the second and third from x=20
    start = 1'b1;
    pix_x = 8'd10;
    pix_y = 16'd5;
    for (int c = 1; c <= 21; c++) begin
      tick();
      check($sformatf("held valid c%0d", c), 64'(valid), 64'((c % 7) == 0));
      check($sformatf("held busy c%0d", c), 64'(busy), 64'd1);
      if (c == 7)  check("held cue1", 64'(cuarenta), 64'h0A_09_0A_0B_0A);
      if (c == 14) check("held cue2", 64'(cuarenta), 64'h14_13_14_15_14);
      if (c == 21) check("held cue3", 64'(cuarenta), 64'h14_13_14_15_14);
      if (c == 1)  pix_x = 8'd20;
      if (c == 21) start = 1'b0;
    end
    tick();
    check("held end valid", 64'(valid), 64'd0);
    check("held end busy", 64'(busy), 64'd0);

    // reset during the third cycle of an interior fetch
    start = 1'b1;
    pix_x = 8'd10;
    pix_y = 16'd5;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort mem_rd", 64'(mem_rd), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort valid", 64'(valid), 64'd0);
    check("abort cuarenta", 64'(cuarenta), 64'd0);
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("abort quiet valid c%0d", c), 64'(valid), 64'd0);
    end
    run_pixel("after_abort", 8'd1, 16'd1, 5'b11111, 1, 256, 257, 258, 513, 40'h01_00_01_02_01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
